stage_tl_mshr: RTL and testbench
================================

// Module: stage_tl_mshr
// PURPOSE
//  Non-blocking miss-handling unit for the TL stage; successor to the single-miss blocking refill path.
//  Tracks up to N_MSHR outstanding D-cache line misses across N_THREADS threads.
//  Merges same-line misses, issues one memory read per cycle and buffers one dirty-victim writeback.
//  Drives per-thread stalled bits and line fills back into the D-cache.
// PARAMETERS
//  N_THREADS    4   hardware threads; stalled width
//  N_MSHR       4   outstanding line misses
//  PADDR_W      20  physical address width (pptr_t)
//  LINE_OFFS_W  4   byte-offset bits in a cache line; line addr = addr[PADDR_W-1:LINE_OFFS_W]
//  LINE_W       128 cacheline_t width
// PORTS
//  clk                 in   1            clock, all state on posedge
//  rst                 in   1            asynchronous reset, active-low
//  miss_en             in   1            D-cache miss for a valid mem instr this cycle
//  miss_thread         in   $clog2(NT)   thread of the missing instr
//  miss_addr           in   PADDR_W      physical address of the miss
//  miss_wb_en          in   1            dirty victim to write back
//  miss_wb_addr        in   PADDR_W      victim line address (offset bits zero)
//  miss_wb_line        in   LINE_W       victim data
//  mem_req_ren         out  1            read request pulse
//  mem_req_raddr       out  PADDR_W      read line address
//  mem_req_wen         out  1            write request pulse
//  mem_req_waddr       out  PADDR_W      write line address
//  mem_req_wcacheline  out  LINE_W       write data
//  mem_rec_en          in   1            memory response valid
//  mem_rec_addr        in   PADDR_W      response line address
//  mem_rec_cacheline   in   LINE_W       response data
//  fill_en             out  1            fill pulse to D-cache
//  fill_addr           out  PADDR_W      filled line address
//  fill_line           out  LINE_W       filled data
//  stalled             out  N_THREADS    bit t = thread t waits on a miss
//  full                out  1            no FREE entry this cycle (combinational)
// BEHAVIOUR
//  - Reset (rst=0, async): all entries FREE, all waiter masks 0, every output 0.
//  - Entry states: FREE -> PEND (allocated) -> WAIT (read issued) -> FREE (response consumed).
//  - Miss, line matches a PEND/WAIT entry: OR thread bit into that entry's waiter mask; no new request.
//  - Miss, no match: allocate the lowest-index FREE entry as PEND with mask = 1<<miss_thread.
//  - Miss while full: not recorded, stalled unchanged; the thread replays and misses again later.
//  - Issue: lowest-index PEND entry -> WAIT; mem_req_ren/raddr are registered, pulsing for 1 cycle.
//    Earliest mem_req_ren is the cycle after allocation; at most one read per cycle.
//  - Writeback: miss_wb_en registers addr/line; mem_req_wen pulses the next cycle.
//    It is independent of the read channel, so both may pulse together; back-to-back wb is accepted.
//  - Response: mem_rec_en matching a WAIT entry -> next cycle fill_en=1 with that addr/data.
//    In that same cycle the entry is FREE and its waiter bits are cleared.
//    A response with no matching WAIT entry is ignored; no fill is issued.
//  - Same-cycle response and miss on the same line: the miss is dropped without stall.
//    The line is filled next cycle, so the replay hits.
//  - An entry freed by a response is not allocatable until the following cycle.
//  - stalled[t] = OR over entries of waiter[t], registered. It rises the cycle after miss_en.
//  - Miss from an already-stalled thread is illegal: flag it with an assertion; mask update is harmless.
//  - Line-address compare ignores the LINE_OFFS_W low bits; no arithmetic wrap.
// STRUCTURE
//  - common pkg: mshr_state_t enum {FREE,PEND,WAIT}, lineaddr_t, N_MSHR, LINE_OFFS_W.
//  - Sub-module mshr_entry: one entry holding state, line address, waiter mask and match compare.
//    Generate it N_MSHR times.
//  - Top level holds: lowest-index priority pick for alloc/issue, wb register, fill register, stalled OR-reduce.
// TESTING
//  1 Reset mid-operation: 2 entries WAIT, drop rst -> stalled=0, fill_en=0, full=0.
//    Late response after reset is ignored.
//  2 Single miss: T1 addr 0x01234 -> mem_req_ren @+1 raddr 0x01230, stalled=0010.
//    Response 0x01230 -> fill_en next cycle, stalled=0000.
//  3 Merge: T0 then T2 miss 0x00400/0x0040C -> exactly one read; stalled=0101.
//    One response clears both bits.
//  4 Full: 4 distinct misses, 5th from T3 -> full=1, no read for 5th, stalled[3]=0.
//  5 Collision: response 0x00800 and T1 miss 0x00804 same cycle -> fill issued, no new read, stalled[1]=0.
//  6 Writeback with read: miss_wb_en 0x0F000 with a new miss -> mem_req_wen and mem_req_ren pulse the same cycle.

Source files
------------

// File: rtl/stage_tl_mshr_pkg.sv
// Shared types and helpers for the TL-stage miss-handling unit.
package stage_tl_mshr_pkg;

   localparam int N_THREADS   = 4;
   localparam int N_MSHR      = 4;
   localparam int PADDR_W     = 20;
   localparam int LINE_OFFS_W = 4;
   localparam int LINE_W      = 128;
   localparam int TID_W       = $clog2(N_THREADS);
   localparam int IDX_W       = $clog2(N_MSHR);
   localparam int LADDR_W     = PADDR_W - LINE_OFFS_W;

   typedef logic [PADDR_W-1:0]   pptr_t;
   typedef logic [LADDR_W-1:0]   lineaddr_t;
   typedef logic [LINE_W-1:0]    cacheline_t;
   typedef logic [N_THREADS-1:0] tmask_t;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      PEND = 2'd1,
      WAIT = 2'd2
   } mshr_state_t;

   // Line address of a byte address (offset bits dropped, no wrap).
   function automatic lineaddr_t line_of(input pptr_t a);
      return a[PADDR_W-1:LINE_OFFS_W];
   endfunction

   // Byte address of the first byte of a line.
   function automatic pptr_t addr_of(input lineaddr_t l);
      return {l, {LINE_OFFS_W{1'b0}}};
   endfunction

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_MSHR-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = N_MSHR - 1; i >= 0; i--) begin
         if (m[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/stage_tl_mshr_chk.sv
// Protocol checker: a thread already waiting on a miss must not miss again.
module stage_tl_mshr_chk
   import stage_tl_mshr_pkg::*;
(
   input logic             clk,
   input logic             rst,
   input logic             chk_en,
   input logic             miss_en,
   input logic [TID_W-1:0] miss_thread,
   input tmask_t           stalled
);

   a_no_miss_while_stalled: assert property (@(posedge clk) disable iff (!rst)
      (chk_en && miss_en) |-> !stalled[miss_thread]);

endmodule

// File: rtl/stage_tl_mshr_entry.sv
// One miss-status holding register: state, line address, waiter mask and
// the line compares used for merging misses and matching responses.
module stage_tl_mshr_entry
   import stage_tl_mshr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_en,
   input  lineaddr_t   miss_line,
   input  tmask_t      miss_tmask,
   input  logic        alloc,
   input  logic        alloc_issue,
   input  logic        issue,
   input  logic        rec_en,
   input  lineaddr_t   rec_line,
   output mshr_state_t state,
   output lineaddr_t   line,
   output tmask_t      waiter_nxt,
   output logic        miss_match,
   output logic        rec_hit
);

   mshr_state_t state_d, state_q;
   lineaddr_t   line_d, line_q;
   tmask_t      waiter_d, waiter_q;
   logic        merge_s;

   assign miss_match = (state_q != FREE) && (line_q == miss_line);
   assign rec_hit    = rec_en && (state_q == WAIT) && (line_q == rec_line);
   assign merge_s    = miss_en && miss_match;

   assign state      = state_q;
   assign line       = line_q;
   assign waiter_nxt = waiter_d;

   // Next entry state; a response wins over a same-line miss so that miss is dropped.
   always_comb begin
      state_d  = state_q;
      line_d   = line_q;
      waiter_d = waiter_q;
      if (rec_hit) begin
         state_d  = FREE;
         waiter_d = '0;
      end else begin
         case (state_q)
            FREE: begin
               if (alloc) begin
                  state_d  = alloc_issue ? WAIT : PEND;
                  line_d   = miss_line;
                  waiter_d = miss_tmask;
               end else begin
                  state_d  = FREE;
               end
            end
            PEND: begin
               if (issue) begin
                  state_d = WAIT;
               end else begin
                  state_d = PEND;
               end
               if (merge_s) begin
                  waiter_d = waiter_q | miss_tmask;
               end else begin
                  waiter_d = waiter_q;
               end
            end
            WAIT: begin
               if (merge_s) begin
                  waiter_d = waiter_q | miss_tmask;
               end else begin
                  waiter_d = waiter_q;
               end
            end
            default: begin
               state_d  = FREE;
               waiter_d = '0;
            end
         endcase
      end
   end

   // Entry state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= FREE;
         line_q   <= '0;
         waiter_q <= '0;
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         waiter_q <= waiter_d;
      end
   end

endmodule

// File: rtl/stage_tl_mshr.sv
// Non-blocking miss handler: N_MSHR entries, lowest-index allocate/issue,
// a one-deep writeback register and a fill register towards the D-cache.
module stage_tl_mshr
   import stage_tl_mshr_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 miss_en,
   input  logic [TID_W-1:0]     miss_thread,
   input  logic [PADDR_W-1:0]   miss_addr,
   input  logic                 miss_wb_en,
   input  logic [PADDR_W-1:0]   miss_wb_addr,
   input  logic [LINE_W-1:0]    miss_wb_line,
   output logic                 mem_req_ren,
   output logic [PADDR_W-1:0]   mem_req_raddr,
   output logic                 mem_req_wen,
   output logic [PADDR_W-1:0]   mem_req_waddr,
   output logic [LINE_W-1:0]    mem_req_wcacheline,
   input  logic                 mem_rec_en,
   input  logic [PADDR_W-1:0]   mem_rec_addr,
   input  logic [LINE_W-1:0]    mem_rec_cacheline,
   output logic                 fill_en,
   output logic [PADDR_W-1:0]   fill_addr,
   output logic [LINE_W-1:0]    fill_line,
   output logic [N_THREADS-1:0] stalled,
   output logic                 full
);

   mshr_state_t       state_s      [N_MSHR];
   lineaddr_t         line_s       [N_MSHR];
   tmask_t            waiter_nxt_s [N_MSHR];
   logic [N_MSHR-1:0] match_s, hit_s, free_s, pend_s, alloc_s, issue_s;
   logic              alloc_req_s, alloc_issue_s;
   logic [IDX_W-1:0]  alloc_idx_s, issue_idx_s;
   lineaddr_t         miss_line_s, rec_line_s;
   tmask_t            miss_tmask_s;
   logic              unused_offs_s;

   logic       ren_d, ren_q, wen_d, wen_q, fill_en_d, fill_en_q;
   pptr_t      raddr_d, raddr_q, waddr_d, waddr_q, fill_addr_d, fill_addr_q;
   cacheline_t wline_d, wline_q, fill_line_d, fill_line_q;
   tmask_t     stalled_d, stalled_q;

   assign miss_line_s   = line_of(miss_addr);
   assign rec_line_s    = line_of(mem_rec_addr);
   assign miss_tmask_s  = tmask_t'(1'b1) << miss_thread;
   assign unused_offs_s = ^{miss_addr[LINE_OFFS_W-1:0], mem_rec_addr[LINE_OFFS_W-1:0]};

   for (genvar g = 0; g < N_MSHR; g++) begin : g_entry
      stage_tl_mshr_entry u_entry (
         .clk         (clk),
         .rst         (rst),
         .miss_en     (miss_en),
         .miss_line   (miss_line_s),
         .miss_tmask  (miss_tmask_s),
         .alloc       (alloc_s[g]),
         .alloc_issue (alloc_issue_s),
         .issue       (issue_s[g]),
         .rec_en      (mem_rec_en),
         .rec_line    (rec_line_s),
         .state       (state_s[g]),
         .line        (line_s[g]),
         .waiter_nxt  (waiter_nxt_s[g]),
         .miss_match  (match_s[g]),
         .rec_hit     (hit_s[g])
      );
      assign free_s[g] = (state_s[g] == FREE);
      assign pend_s[g] = (state_s[g] == PEND);
   end

   // An entry freed by a response this cycle still reads as busy, so it is not reused yet.
   assign full        = ~(|free_s);
   assign alloc_req_s = miss_en && !(|match_s) && (|free_s);
   assign alloc_idx_s = lowest_idx(free_s);
   assign issue_idx_s = lowest_idx(pend_s);

   // Allocation and read issue; a fresh miss goes straight out when nothing older is pending.
   always_comb begin
      alloc_s       = '0;
      issue_s       = '0;
      alloc_issue_s = 1'b0;
      ren_d         = 1'b0;
      raddr_d       = raddr_q;
      if (alloc_req_s) begin
         alloc_s[alloc_idx_s] = 1'b1;
      end else begin
         alloc_s = '0;
      end
      if (|pend_s) begin
         issue_s[issue_idx_s] = 1'b1;
         ren_d                = 1'b1;
         raddr_d              = addr_of(line_s[issue_idx_s]);
      end else if (alloc_req_s) begin
         alloc_issue_s = 1'b1;
         ren_d         = 1'b1;
         raddr_d       = addr_of(miss_line_s);
      end else begin
         ren_d = 1'b0;
      end
   end

   // Fill, writeback and stall next values.
   always_comb begin
      stalled_d = '0;
      for (int i = 0; i < N_MSHR; i++) begin
         stalled_d = stalled_d | waiter_nxt_s[i];
      end
      fill_en_d   = |hit_s;
      fill_addr_d = fill_addr_q;
      fill_line_d = fill_line_q;
      if (|hit_s) begin
         fill_addr_d = addr_of(rec_line_s);
         fill_line_d = mem_rec_cacheline;
      end else begin
         fill_addr_d = fill_addr_q;
         fill_line_d = fill_line_q;
      end
      wen_d   = miss_wb_en;
      waddr_d = waddr_q;
      wline_d = wline_q;
      if (miss_wb_en) begin
         waddr_d = miss_wb_addr;
         wline_d = miss_wb_line;
      end else begin
         waddr_d = waddr_q;
         wline_d = wline_q;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ren_q       <= 1'b0;
         raddr_q     <= '0;
         wen_q       <= 1'b0;
         waddr_q     <= '0;
         wline_q     <= '0;
         fill_en_q   <= 1'b0;
         fill_addr_q <= '0;
         fill_line_q <= '0;
         stalled_q   <= '0;
      end else begin
         ren_q       <= ren_d;
         raddr_q     <= raddr_d;
         wen_q       <= wen_d;
         waddr_q     <= waddr_d;
         wline_q     <= wline_d;
         fill_en_q   <= fill_en_d;
         fill_addr_q <= fill_addr_d;
         fill_line_q <= fill_line_d;
         stalled_q   <= stalled_d;
      end
   end

   assign mem_req_ren        = ren_q;
   assign mem_req_raddr      = raddr_q;
   assign mem_req_wen        = wen_q;
   assign mem_req_waddr      = waddr_q;
   assign mem_req_wcacheline = wline_q;
   assign fill_en            = fill_en_q;
   assign fill_addr          = fill_addr_q;
   assign fill_line          = fill_line_q;
   assign stalled            = stalled_q;

endmodule

// File: tb/tb_stage_tl_mshr.sv
// Bench for stage_tl_mshr: directed scenarios, a transaction-level model
// compared every cycle, and literal expectations at key points.
module tb_stage_tl_mshr;
   import stage_tl_mshr_pkg::*;

   logic          clk, rst, chk_en;
   logic          miss_en, miss_wb_en, mem_rec_en;
   logic [1:0]    miss_thread;
   logic [19:0]   miss_addr, miss_wb_addr, mem_rec_addr;
   logic [127:0]  miss_wb_line, mem_rec_cacheline;
   logic          mem_req_ren, mem_req_wen, fill_en, full;
   logic [19:0]   mem_req_raddr, mem_req_waddr, fill_addr;
   logic [127:0]  mem_req_wcacheline, fill_line;
   logic [3:0]    stalled;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: outstanding lines and the outputs they imply.
   logic          m_valid  [N_MSHR];
   logic          m_issued [N_MSHR];
   logic [15:0]   m_line   [N_MSHR];
   logic [3:0]    m_mask   [N_MSHR];
   logic          e_ren, e_wen, e_fill;
   logic [19:0]   e_raddr, e_waddr, e_faddr;
   logic [127:0]  e_wline, e_fline;
   logic [3:0]    e_stalled;

   stage_tl_mshr dut (
      .clk(clk), .rst(rst), .miss_en(miss_en), .miss_thread(miss_thread), .miss_addr(miss_addr),
      .miss_wb_en(miss_wb_en), .miss_wb_addr(miss_wb_addr), .miss_wb_line(miss_wb_line),
      .mem_req_ren(mem_req_ren), .mem_req_raddr(mem_req_raddr), .mem_req_wen(mem_req_wen),
      .mem_req_waddr(mem_req_waddr), .mem_req_wcacheline(mem_req_wcacheline),
      .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr), .mem_rec_cacheline(mem_rec_cacheline),
      .fill_en(fill_en), .fill_addr(fill_addr), .fill_line(fill_line),
      .stalled(stalled), .full(full)
   );

   stage_tl_mshr_chk u_chk (
      .clk(clk), .rst(rst), .chk_en(chk_en), .miss_en(miss_en),
      .miss_thread(miss_thread), .stalled(stalled)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < N_MSHR; i++) begin
         m_valid[i] = 1'b0; m_issued[i] = 1'b0; m_line[i] = '0; m_mask[i] = '0;
      end
      e_ren = 1'b0; e_wen = 1'b0; e_fill = 1'b0; e_stalled = '0;
      e_raddr = '0; e_waddr = '0; e_faddr = '0; e_wline = '0; e_fline = '0;
   endtask

   // One clock of the spec-level model: response, miss merge/alloc, one read, writeback.
   task automatic m_step();
      int hit, match, alloc, iss;
      logic [15:0] ml, rl;
      logic all_busy;
      hit = -1; match = -1; alloc = -1; iss = -1;
      ml = miss_addr[19:4];
      rl = mem_rec_addr[19:4];
      all_busy = 1'b1;
      for (int i = 0; i < N_MSHR; i++) if (!m_valid[i]) all_busy = 1'b0;
      if (mem_rec_en)
         for (int i = 0; i < N_MSHR; i++)
            if (m_valid[i] && m_issued[i] && m_line[i] == rl) hit = i;
      e_fill = (hit >= 0);
      if (hit >= 0) begin
         e_faddr = {rl, 4'h0};
         e_fline = mem_rec_cacheline;
      end
      if (miss_en) begin
         for (int i = 0; i < N_MSHR; i++) if (m_valid[i] && m_line[i] == ml) match = i;
         if (match >= 0) begin
            if (match != hit) m_mask[match] = m_mask[match] | (4'b0001 << miss_thread);
         end else if (!all_busy) begin
            for (int i = N_MSHR - 1; i >= 0; i--) if (!m_valid[i]) alloc = i;
            m_valid[alloc] = 1'b1; m_issued[alloc] = 1'b0;
            m_line[alloc] = ml; m_mask[alloc] = 4'b0001 << miss_thread;
         end
      end
      if (hit >= 0) begin
         m_valid[hit] = 1'b0; m_issued[hit] = 1'b0; m_mask[hit] = '0;
      end
      for (int i = N_MSHR - 1; i >= 0; i--)
         if (i != alloc && m_valid[i] && !m_issued[i]) iss = i;
      if (iss < 0 && alloc >= 0) iss = alloc;
      e_ren = (iss >= 0);
      if (iss >= 0) begin
         m_issued[iss] = 1'b1;
         e_raddr = {m_line[iss], 4'h0};
      end
      e_wen = miss_wb_en;
      if (miss_wb_en) begin
         e_waddr = miss_wb_addr;
         e_wline = miss_wb_line;
      end
      e_stalled = '0;
      for (int i = 0; i < N_MSHR; i++) e_stalled = e_stalled | m_mask[i];
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) m_reset();
         else m_step();
      end
   end

   // Compare DUT against the model on every clock out of reset.
   initial begin
      logic e_full;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            e_full = 1'b1;
            for (int i = 0; i < N_MSHR; i++) if (!m_valid[i]) e_full = 1'b0;
            chk("mon_ren", 128'(mem_req_ren), 128'(e_ren));
            chk("mon_wen", 128'(mem_req_wen), 128'(e_wen));
            chk("mon_fill_en", 128'(fill_en), 128'(e_fill));
            chk("mon_stalled", 128'(stalled), 128'(e_stalled));
            chk("mon_full", 128'(full), 128'(e_full));
            if (e_ren) chk("mon_raddr", 128'(mem_req_raddr), 128'(e_raddr));
            if (e_wen) begin
               chk("mon_waddr", 128'(mem_req_waddr), 128'(e_waddr));
               chk("mon_wline", mem_req_wcacheline, e_wline);
            end
            if (e_fill) begin
               chk("mon_faddr", 128'(fill_addr), 128'(e_faddr));
               chk("mon_fline", fill_line, e_fline);
            end
         end
      end
   end

   task automatic clear_in();
      miss_en = 1'b0; miss_thread = 2'd0; miss_addr = 20'h0;
      miss_wb_en = 1'b0; miss_wb_addr = 20'h0; miss_wb_line = 128'h0;
      mem_rec_en = 1'b0; mem_rec_addr = 20'h0; mem_rec_cacheline = 128'h0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      clear_in();
   endtask

   task automatic miss(input logic [1:0] t, input logic [19:0] a);
      miss_en = 1'b1; miss_thread = t; miss_addr = a;
   endtask

   task automatic resp(input logic [19:0] a, input logic [127:0] d);
      mem_rec_en = 1'b1; mem_rec_addr = a; mem_rec_cacheline = d;
   endtask

   initial begin
      chk_en = 1'b1;
      rst = 1'b0;
      clear_in();
      repeat (2) @(negedge clk);
      chk("rst_stalled", 128'(stalled), 128'(4'b0000));
      chk("rst_fill_en", 128'(fill_en), 128'(1'b0));
      chk("rst_ren", 128'(mem_req_ren), 128'(1'b0));
      chk("rst_wen", 128'(mem_req_wen), 128'(1'b0));
      chk("rst_full", 128'(full), 128'(1'b0));
      rst = 1'b1;
      step();

      // Single miss
      miss(2'd1, 20'h01234); step();
      chk("single_ren", 128'(mem_req_ren), 128'(1'b1));
      chk("single_raddr", 128'(mem_req_raddr), 128'(20'h01230));
      chk("single_stalled", 128'(stalled), 128'(4'b0010));
      step();
      chk("single_ren_pulse", 128'(mem_req_ren), 128'(1'b0));
      resp(20'h01230, 128'hA1A1); step();
      chk("single_fill_en", 128'(fill_en), 128'(1'b1));
      chk("single_fill_addr", 128'(fill_addr), 128'(20'h01230));
      chk("single_fill_line", fill_line, 128'hA1A1);
      chk("single_unstall", 128'(stalled), 128'(4'b0000));
      step();

      // Merge of two threads on one line
      miss(2'd0, 20'h00400); step();
      chk("merge_ren", 128'(mem_req_ren), 128'(1'b1));
      miss(2'd2, 20'h0040C); step();
      chk("merge_no_read", 128'(mem_req_ren), 128'(1'b0));
      chk("merge_stalled", 128'(stalled), 128'(4'b0101));
      step();
      resp(20'h00400, 128'hB2B2); step();
      chk("merge_fill", 128'(fill_en), 128'(1'b1));
      chk("merge_unstall", 128'(stalled), 128'(4'b0000));
      resp(20'h77770, 128'hDEAD); step();
      chk("stray_resp_ignored", 128'(fill_en), 128'(1'b0));

      // Fill all entries, then a miss while full
      miss(2'd0, 20'h10000); step();
      miss(2'd1, 20'h20000); step();
      miss(2'd2, 20'h30000); step();
      chk_en = 1'b0;
      miss(2'd0, 20'h40000); step();
      chk_en = 1'b1;
      chk("full_set", 128'(full), 128'(1'b1));
      chk("full_last_raddr", 128'(mem_req_raddr), 128'(20'h40000));
      miss(2'd3, 20'h50000); step();
      chk("full_no_read", 128'(mem_req_ren), 128'(1'b0));
      chk("full_stalled", 128'(stalled), 128'(4'b0111));
      resp(20'h10000, 128'h1); step();
      resp(20'h20000, 128'h2); step();
      resp(20'h30000, 128'h3); step();
      resp(20'h40000, 128'h4); step();
      chk("drain_full", 128'(full), 128'(1'b0));
      chk("drain_stalled", 128'(stalled), 128'(4'b0000));

      // Response and same-line miss in one cycle
      miss(2'd0, 20'h00800); step();
      resp(20'h00800, 128'hC5C5); miss(2'd1, 20'h00804); step();
      chk("coll_fill", 128'(fill_en), 128'(1'b1));
      chk("coll_fill_addr", 128'(fill_addr), 128'(20'h00800));
      chk("coll_no_read", 128'(mem_req_ren), 128'(1'b0));
      chk("coll_stalled", 128'(stalled), 128'(4'b0000));

      // Writeback alongside a read, then back-to-back writebacks
      miss_wb_en = 1'b1; miss_wb_addr = 20'h0F000; miss_wb_line = 128'hF0F0;
      miss(2'd2, 20'h0A000); step();
      chk("wb_wen", 128'(mem_req_wen), 128'(1'b1));
      chk("wb_ren", 128'(mem_req_ren), 128'(1'b1));
      chk("wb_waddr", 128'(mem_req_waddr), 128'(20'h0F000));
      chk("wb_raddr", 128'(mem_req_raddr), 128'(20'h0A000));
      miss_wb_en = 1'b1; miss_wb_addr = 20'h0E000; miss_wb_line = 128'hE0E0; step();
      miss_wb_en = 1'b1; miss_wb_addr = 20'h0D000; miss_wb_line = 128'hD0D0; step();
      chk("wb_b2b_wen", 128'(mem_req_wen), 128'(1'b1));
      chk("wb_b2b_line", mem_req_wcacheline, 128'hD0D0);
      step();
      chk("wb_pulse_end", 128'(mem_req_wen), 128'(1'b0));
      resp(20'h0A000, 128'hAAAA); step();
      step();

      // Reset with two reads outstanding
      miss(2'd0, 20'h11110); step();
      miss(2'd1, 20'h22220); step();
      chk("pre_rst_stalled", 128'(stalled), 128'(4'b0011));
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_stalled", 128'(stalled), 128'(4'b0000));
      chk("mid_rst_fill_en", 128'(fill_en), 128'(1'b0));
      chk("mid_rst_full", 128'(full), 128'(1'b0));
      chk("mid_rst_ren", 128'(mem_req_ren), 128'(1'b0));
      @(negedge clk);
      rst = 1'b1;
      resp(20'h11110, 128'h5555); step();
      chk("late_resp_ignored", 128'(fill_en), 128'(1'b0));
      chk("late_resp_stalled", 128'(stalled), 128'(4'b0000));
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
